// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: burst read/write of NUM_OUT_REGS control
// registers and NUM_IN_REGS read-only input registers, with auto-increment
// addressing and per-register write/read strobes. All SPI pins are
// oversampled by clk through 2-FF synchronisers.
module spi_reg_bank #(
  parameter int unsigned NUM_OUT_REGS = 8,
  parameter int unsigned NUM_IN_REGS  = 4,
  parameter logic [7:0]  OUT_RST_VAL  = 8'h00
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic                                                 spi_cs_n,
  input  logic                                                 spi_clk,
  input  logic                                                 spi_mosi,
  output logic                                                 spi_miso,
  output logic                                                 spi_miso_oe,
  input  logic [((NUM_IN_REGS == 0) ? 8 : NUM_IN_REGS*8)-1:0]  in_regs,
  output logic [NUM_OUT_REGS*8-1:0]                            out_regs,
  output logic [NUM_OUT_REGS-1:0]                              wr_stb,
  output logic [NUM_OUT_REGS+NUM_IN_REGS-1:0]                  rd_stb,
  output logic                                                 busy
);

  localparam int unsigned NUM_ADDR = NUM_OUT_REGS + NUM_IN_REGS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;

  logic cs_meta, cs_sync;
  logic sclk_meta, sclk_sync, sclk_d;
  logic mosi_meta, mosi_sync;

  logic       armed;
  logic       rw;
  logic [6:0] addr;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;

  logic                sclk_rise_c;
  logic                sclk_fall_c;
  logic                byte_done_c;
  logic [7:0]          byte_c;
  logic [6:0]          ld_addr_c;
  logic [7:0]          ld_data_c;
  logic [NUM_ADDR-1:0] ld_stb_c;

  // Pin synchronisers; cs_n clears low so a stale reset value can never arm the FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      sclk_meta <= spi_clk;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // Edge detect, assembled byte and read-load source mux for the address about to be loaded
  always_comb begin
    sclk_rise_c = sclk_sync & ~sclk_d;
    sclk_fall_c = ~sclk_sync & sclk_d;
    byte_c      = {shift_in, mosi_sync};
    byte_done_c = sclk_rise_c && (bit_cnt == 3'd7);
    ld_addr_c   = (state == CMD) ? byte_c[6:0] : 7'(addr + 7'd1);
    ld_data_c   = 8'h00;
    ld_stb_c    = '0;
    for (int unsigned k = 0; k < NUM_OUT_REGS; k++) begin
      if (ld_addr_c == 7'(k)) begin
        ld_data_c   = out_regs[8*k +: 8];
        ld_stb_c[k] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_IN_REGS; k++) begin
      if (ld_addr_c == 7'(NUM_OUT_REGS + k)) begin
        ld_data_c                  = in_regs[8*k +: 8];
        ld_stb_c[NUM_OUT_REGS + k] = 1'b1;
      end
    end
  end

  // Frame FSM, register file and miso shifter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      rw          <= 1'b0;
      addr        <= '0;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      out_regs    <= {NUM_OUT_REGS{OUT_RST_VAL}};
      wr_stb      <= '0;
      rd_stb      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_stb <= '0;
      rd_stb <= '0;
      if (cs_sync) begin
        // Deselect aborts any partial byte; a high cs_n also arms the next frame
        state       <= IDLE;
        armed       <= 1'b1;
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        if (state != IDLE && sclk_rise_c) begin
          shift_in <= byte_c[6:0];
          bit_cnt  <= 3'(bit_cnt + 3'd1);
        end
        case (state)
          IDLE: begin
            if (armed) begin
              state   <= CMD;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (byte_done_c) begin
              rw    <= byte_c[7];
              addr  <= byte_c[6:0];
              state <= DATA;
              if (byte_c[7]) begin
                shift_out   <= ld_data_c;
                spi_miso    <= ld_data_c[7];
                spi_miso_oe <= 1'b1;
                rd_stb      <= ld_stb_c;
              end
            end
          end
          DATA: begin
            if (byte_done_c) begin
              addr <= ld_addr_c;
              if (rw) begin
                shift_out   <= ld_data_c;
                spi_miso    <= ld_data_c[7];
                spi_miso_oe <= 1'b1;
                rd_stb      <= ld_stb_c;
              end else begin
                for (int unsigned k = 0; k < NUM_OUT_REGS; k++) begin
                  if (addr == 7'(k)) begin
                    out_regs[8*k +: 8] <= byte_c;
                    wr_stb[k]          <= 1'b1;
                  end
                end
              end
            end else if (sclk_fall_c && rw && bit_cnt != 3'd0) begin
              // The fall that closes a byte follows a fresh load, so it must not shift
              spi_miso  <= shift_out[6];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: hand sequences plus a vector table; strobe and
// miso expectations flow through scoreboard queues.
module tb_spi_reg_bank;

  localparam int NO   = 8;
  localparam int NI   = 4;
  localparam int NA   = NO + NI;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic [NI*8-1:0] in_regs = 32'h3C96C35A;
  logic [NO*8-1:0] out_regs;
  logic [NO-1:0] wr_stb;
  logic [NA-1:0] rd_stb;
  logic          busy;

  spi_reg_bank #(
    .NUM_OUT_REGS(NO),
    .NUM_IN_REGS (NI),
    .OUT_RST_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .in_regs    (in_regs),
    .out_regs   (out_regs),
    .wr_stb     (wr_stb),
    .rd_stb     (rd_stb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } wr_exp_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_rx;
  } vec_t;

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  wr_exp_t    wr_q[$];
  int         rd_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] mdl[NO];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [NO*8-1:0] mdl_pack();
    logic [NO*8-1:0] p;
    for (int k = 0; k < NO; k++) p[8*k +: 8] = mdl[k];
    return p;
  endfunction

  // Strobe scoreboard: each pulse pops the next expected entry
  always @(negedge clk) begin
    if (reset_n && wr_stb != '0) begin
      if (wr_q.size() == 0) check("wr_stb_unexpected", 64'(wr_stb), 64'd0);
      else begin
        wr_exp_t    e;
        logic [NO-1:0] ev;
        e = wr_q.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        check("wr_stb", 64'(wr_stb), 64'(ev));
        check("wr_data", 64'(out_regs[8*e.idx +: 8]), 64'(e.val));
        check("wr_latency", 64'(cyc - rise_cyc), 64'd3);
      end
    end
    if (reset_n && rd_stb != '0) begin
      if (rd_q.size() == 0) check("rd_stb_unexpected", 64'(rd_stb), 64'd0);
      else begin
        int            i;
        logic [NA-1:0] ev;
        i = rd_q.pop_front();
        ev = '0;
        ev[i] = 1'b1;
        check("rd_stb", 64'(rd_stb), 64'(ev));
        check("rd_latency", 64'(cyc - rise_cyc), 64'd3);
      end
    end
  end

  task automatic exp_write(input int a, input logic [7:0] d);
    wr_exp_t e;
    if (a < NO) begin
      mdl[a] = d;
      e.idx = a;
      e.val = d;
      wr_q.push_back(e);
    end
  endtask

  // A read of n data bytes loads n+1 addresses (command byte plus each data byte)
  task automatic rd_loads(input int a0, input int n);
    for (int j = 0; j <= n; j++) begin
      int a;
      a = (a0 + j) % 128;
      if (a < NA) rd_q.push_back(a);
    end
  endtask

  task automatic sbit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r = spi_miso;
    spi_clk = 1'b1;
    rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe);
    logic r;
    rx = 8'h00;
    oe = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (i == 7) begin
        spi_mosi = tx[i];
        repeat (HALF) @(negedge clk);
        oe = spi_miso_oe;
        r = spi_miso;
        spi_clk = 1'b1;
        rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
      end else sbit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int n, input int last_bits);
    logic [7:0] tx[4];
    logic [7:0] rx;
    logic [7:0] c;
    logic [7:0] e;
    logic       oe;
    int         nb;
    tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
    c = b0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_start", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1) ? last_bits : 8;
      sbyte(tx[i], nb, rx, oe);
      if (i == 0) check("miso_oe_cmd", 64'(oe), 64'd0);
      else if (nb == 8) begin
        check("miso_oe_data", 64'(oe), 64'(c[7]));
        if (c[7]) begin
          e = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hxx;
          check("miso_byte", 64'(rx), 64'(e));
        end
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_end", 64'(busy), 64'd0);
    check("miso_oe_end", 64'(spi_miso_oe), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[12];
    logic [7:0] rx;
    logic [7:0] c;
    logic       oe;

    vt[0]  = '{cmd: 8'h01, data: 8'h3C, exp_rx: 8'h00};
    vt[1]  = '{cmd: 8'h81, data: 8'h00, exp_rx: 8'h3C};
    vt[2]  = '{cmd: 8'h82, data: 8'h00, exp_rx: 8'hA5};
    vt[3]  = '{cmd: 8'h8A, data: 8'h00, exp_rx: 8'h96};
    vt[4]  = '{cmd: 8'h8B, data: 8'h00, exp_rx: 8'h3C};
    vt[5]  = '{cmd: 8'h0C, data: 8'h5E, exp_rx: 8'h00};
    vt[6]  = '{cmd: 8'h8C, data: 8'h00, exp_rx: 8'h00};
    vt[7]  = '{cmd: 8'h07, data: 8'hFF, exp_rx: 8'h00};
    vt[8]  = '{cmd: 8'h87, data: 8'h00, exp_rx: 8'hFF};
    vt[9]  = '{cmd: 8'h86, data: 8'h00, exp_rx: 8'h11};
    vt[10] = '{cmd: 8'h04, data: 8'h69, exp_rx: 8'h00};
    vt[11] = '{cmd: 8'h84, data: 8'h00, exp_rx: 8'h69};

    for (int k = 0; k < NO; k++) mdl[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_regs", 64'(out_regs), 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);
    check("rst_rd_stb", 64'(rd_stb), 64'd0);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write
    exp_write(2, 8'hA5);
    frame(8'h02, 8'hA5, 8'h00, 8'h00, 2, 8);
    check("t1_out_regs", 64'(out_regs), 64'(mdl_pack()));

    // Burst write running past the last output register
    exp_write(6, 8'h11);
    exp_write(7, 8'h22);
    exp_write(8, 8'h33);
    frame(8'h06, 8'h11, 8'h22, 8'h33, 4, 8);
    check("t2_out_regs", 64'(out_regs), 64'(mdl_pack()));

    // Burst read of input registers
    miso_q.push_back(8'h5A);
    miso_q.push_back(8'hC3);
    rd_loads(8, 2);
    frame(8'h88, 8'h00, 8'h00, 8'h00, 3, 8);

    // Unmapped read wrapping to address 0
    exp_write(0, 8'hD4);
    frame(8'h00, 8'hD4, 8'h00, 8'h00, 2, 8);
    miso_q.push_back(8'h00);
    miso_q.push_back(8'hD4);
    rd_loads(127, 2);
    frame(8'hFF, 8'h00, 8'h00, 8'h00, 3, 8);

    // Vector table of single-byte transactions
    for (int i = 0; i < 12; i++) begin
      c = vt[i].cmd;
      if (c[7]) begin
        miso_q.push_back(vt[i].exp_rx);
        rd_loads(int'(c[6:0]), 1);
      end else exp_write(int'(c[6:0]), vt[i].data);
      frame(vt[i].cmd, vt[i].data, 8'h00, 8'h00, 2, 8);
      check("vec_out_regs", 64'(out_regs), 64'(mdl_pack()));
    end

    // Deselect after 5 bits of a write data byte, then a normal frame
    frame(8'h03, 8'hEE, 8'h00, 8'h00, 2, 5);
    check("t5_out_regs", 64'(out_regs), 64'(mdl_pack()));
    exp_write(3, 8'h77);
    frame(8'h03, 8'h77, 8'h00, 8'h00, 2, 8);
    check("t5_next_out_regs", 64'(out_regs), 64'(mdl_pack()));

    // Reset in the middle of a read burst
    rd_loads(8, 0);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    sbyte(8'h88, 8, rx, oe);
    sbyte(8'h00, 3, rx, oe);
    reset_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NO; k++) mdl[k] = 8'h00;
    check("t6_out_regs", 64'(out_regs), 64'd0);
    check("t6_wr_stb", 64'(wr_stb), 64'd0);
    check("t6_rd_stb", 64'(rd_stb), 64'd0);
    check("t6_miso", 64'(spi_miso), 64'd0);
    check("t6_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    sbyte(8'hFF, 8, rx, oe);
    check("t6_hold_miso_oe", 64'(spi_miso_oe), 64'd0);
    check("t6_hold_busy", 64'(busy), 64'd0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    miso_q.push_back(8'h00);
    rd_loads(2, 1);
    frame(8'h82, 8'h00, 8'h00, 8'h00, 2, 8);

    repeat (10) @(negedge clk);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("miso_q_drained", 64'(miso_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
